// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: funct codes,
// FSM states and default datapath width.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // The four mult/div funct codes share the 0110xx prefix.
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional two's-complement negate, used both to take
// operand magnitudes and to restore result signs.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  logic signed [W-1:0] sval;

  assign sval   = signed'(value);
  assign result = negate ? unsigned'(-sval) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Fixed 33-cycle latency: capture, WIDTH iterations, sign fix-up.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               start_acc, op_signed, op_div_in, dbz_in, s1, s2;
  logic [WIDTH-1:0]   abs1, abs2, cap1;
  logic               is_div, sgn_pq, sgn_r, dbz, done_r;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod_fix;
  logic [WIDTH-1:0]   opb, quo_fix, rem_fix, div_rem;
  logic [WIDTH:0]     mul_sum;
  logic               div_ge;

  assign start_acc = (state == IDLE) && start && is_muldiv(func);
  assign op_signed = ~func[0];
  assign op_div_in = func[1];
  assign s1        = op_signed & input1[WIDTH-1];
  assign s2        = op_signed & input2[WIDTH-1];
  assign dbz_in    = op_div_in && (input2 == '0);
  // A zero divisor keeps the raw dividend and no sign fix, so the iterations
  // naturally leave lo = all ones and hi = original input1.
  assign cap1      = dbz_in ? input1 : abs1;

  muldiv_sign_fix #(.W(WIDTH)) u_abs1 (.value(input1), .negate(s1), .result(abs1));
  muldiv_sign_fix #(.W(WIDTH)) u_abs2 (.value(input2), .negate(s2), .result(abs2));

  // acc holds {upper, lower}: product accumulator, or {remainder, quotient}.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign div_ge  = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opb};
  assign div_rem = acc[2*WIDTH-2:WIDTH-1] - opb;

  always_comb begin
    acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    if (is_div)
      acc_nxt = div_ge ? {div_rem, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
  end

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (.value(acc), .negate(sgn_pq), .result(prod_fix));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (.value(acc[WIDTH-1:0]), .negate(sgn_pq), .result(quo_fix));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .negate(sgn_r), .result(rem_fix));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      done_r <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done_r <= (state == FIX);
      if (start_acc) begin
        cnt <= '0;
        dbz <= dbz_in;
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
      end
      if (state == FIX) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end else if (state == IDLE && !start_acc) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

  // Datapath registers carry no reset; they are always reloaded at start.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      is_div <= op_div_in;
      sgn_pq <= ~dbz_in & (s1 ^ s2);
      sgn_r  <= ~dbz_in & s1;
      opb    <= op_div_in ? abs2 : cap1;
      acc    <= {{WIDTH{1'b0}}, (op_div_in ? cap1 : abs2)};
    end else if (state == CALC) begin
      acc <= acc_nxt;
    end
  end

  assign busy        = (state != IDLE);
  assign done        = done_r;
  assign div_by_zero = dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we;
  logic [5:0]   func;
  logic [W-1:0] input1, input2, wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           start_cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_assert = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [W-1:0] mdl_hi = '0, mdl_lo = '0, pend_hi, pend_lo;
  logic [5:0]   fn_tab [4] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func),
    .input1(input1), .input2(input2), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [5:0] f, input logic [W-1:0] a, b,
                                output logic [W-1:0] eh, el, output logic ez);
    longint sa, sbv, p;
    logic [63:0] up;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ez  = 1'b0;
    eh  = '0;
    el  = '0;
    if (f == FN_MULT) begin
      p = sa * sbv;
      {eh, el} = p;
    end else if (f == FN_MULTU) begin
      up = {32'b0, a} * {32'b0, b};
      {eh, el} = up;
    end else if (b == '0) begin
      el = '1;
      eh = a;
      ez = 1'b1;
    end else if (f == FN_DIV) begin
      el = 32'(sa / sbv);
      eh = 32'(sa % sbv);
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 9));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, b, input bit we);
    exp_t e;
    logic [W-1:0] eh, el;
    logic ez;
    @(negedge clk);
    func = f; input1 = a; input2 = b; start = 1'b1;
    hi_we = we; lo_we = we; wdata = 32'h5A5AA5A5;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    model(f, a, b, eh, el, ez);
    e.hi = eh; e.lo = el; e.dz = ez; e.start_cyc = cyc;
    pend_hi = eh; pend_lo = el;
    sb.push_back(e);
    if (we) begin
      chk("we_at_start_hi", hi, mdl_hi);
      chk("we_at_start_lo", lo, mdl_lo);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 33);
    mdl_hi = pend_hi;
    mdl_lo = pend_lo;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("res_hi", hi, e.hi);
          chk("res_lo", lo, e.lo);
          chk("res_dbz", div_by_zero, e.dz);
          chk("latency", cyc - e.start_cyc, 33);
          chk("busy_at_done", busy, 0);
          @(negedge clk);
          chk("done_pulse", done, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic hw, lw;
    logic [W-1:0] d;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    func = '0; input1 = '0; input2 = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    issue(FN_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);      wait_idle();
    issue(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); wait_idle();
    issue(FN_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);       wait_idle();
    issue(FN_DIVU, 32'd7, 32'd2, 1'b0);             wait_idle();
    issue(FN_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0); wait_idle();
    issue(FN_DIV, 32'h12345678, 32'h0, 1'b0);       wait_idle();
    @(negedge clk);
    chk("dbz_sticky", div_by_zero, 1);
    issue(FN_MULT, 32'd3, 32'd4, 1'b0);
    chk("dbz_clear_at_start", div_by_zero, 0);
    wait_idle();

    // Start and MTHI while busy must both be dropped.
    issue(FN_MULT, 32'h00010000, 32'h00010000, 1'b0);
    fork
      wait_idle();
      begin
        repeat (5) @(negedge clk);
        func = FN_MULTU; input1 = 32'd2; input2 = 32'd2; start = 1'b1;
        hi_we = 1'b1; wdata = 32'hAAAA5555;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        chk("calc_hi_stable", hi, mdl_hi);
        chk("calc_lo_stable", lo, mdl_lo);
      end
    join

    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA5555;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both_hi", hi, 32'hAAAA5555);
    chk("mt_both_lo", lo, 32'hAAAA5555);
    mdl_hi = 32'hAAAA5555; mdl_lo = 32'hAAAA5555;

    // Invalid funct: start ignored, so the same-edge MTHI goes through.
    start = 1'b1; func = 6'b100000; hi_we = 1'b1; wdata = 32'h13579BDF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("bad_func_busy", busy, 0);
    chk("bad_func_mthi", hi, 32'h13579BDF);
    chk("bad_func_lo", lo, mdl_lo);
    mdl_hi = 32'h13579BDF;

    // Reset in the middle of a divide.
    issue(FN_DIV, 32'h7FFF0000, 32'h00000123, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    mdl_hi = '0; mdl_lo = '0;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    issue(FN_DIVU, 32'd100, 32'd7, 1'b0); wait_idle();

    for (int i = 0; i < 40; i++) begin
      issue(fn_tab[$urandom_range(0, 3)], rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
      wait_idle();
      if ($urandom_range(0, 3) == 0) begin
        hw = 1'($urandom_range(0, 1));
        lw = 1'($urandom_range(0, 1));
        d  = 32'($urandom());
        hi_we = hw; lo_we = lw; wdata = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (hw) mdl_hi = d;
        if (lw) mdl_lo = d;
        chk("rand_mt_hi", hi, mdl_hi);
        chk("rand_mt_lo", lo, mdl_lo);
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
